// File: rtl/lsu_dbus_ctrl_pkg.sv
// Shared types and constants for the LSU data-bus request path.
// Contents: FSM state type, store/load size mask encodings, exception
// cause codes and the alignment-check helper used at issue time.
package lsu_dbus_ctrl_pkg;

  typedef enum logic [2:0] {
    LSU_IDLE  = 3'd0,
    LSU_REQ   = 3'd1,
    LSU_RSP   = 3'd2,
    LSU_DONE  = 3'd3,
    LSU_DRAIN = 3'd4
  } lsu_state_e;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic [1:0] {
    CAUSE_NONE        = 2'b00,
    CAUSE_LD_MISALIGN = 2'b01,
    CAUSE_ST_MISALIGN = 2'b10,
    CAUSE_TIMEOUT     = 2'b11
  } lsu_cause_e;

  // Half needs addr[0]=0, word needs addr[1:0]=0; bytes are always aligned.
  function automatic logic is_misaligned(input logic [3:0] size, input logic [1:0] lo);
    return ((size == MASK_H) && lo[0]) || ((size == MASK_W) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_dbus_ctrl_store_align.sv
// Store lane alignment: builds the byte write mask and lane-replicated
// write data from the address low bits and store size.
// Ports:
//   i_addr_lo  address bits [1:0]
//   i_s_mask   store size (0001 byte, 0011 half, 1111 word)
//   i_data     raw rs2 store data
//   o_wmask    byte enables
//   o_wdata    replicated store data
module lsu_dbus_ctrl_store_align
  import lsu_dbus_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [1:0]      i_addr_lo,
  input  logic [3:0]      i_s_mask,
  input  logic [XLEN-1:0] i_data,
  output logic [3:0]      o_wmask,
  output logic [XLEN-1:0] o_wdata
);

  always_comb begin
    o_wmask = '0;
    o_wdata = '0;
    case (i_s_mask)
      MASK_B: begin
        o_wmask = MASK_B << i_addr_lo;
        o_wdata = {(XLEN/8){i_data[7:0]}};
      end
      MASK_H: begin
        o_wmask = MASK_H << i_addr_lo;
        o_wdata = {(XLEN/16){i_data[15:0]}};
      end
      MASK_W: begin
        o_wmask = MASK_W;
        o_wdata = i_data;
      end
      default: begin
        o_wmask = '0;
        o_wdata = '0;
      end
    endcase
  end

endmodule

// File: rtl/lsu_dbus_ctrl.sv
// LSU data-bus request controller between EX and MEM.
// Accepts one load/store from EX, checks alignment, issues a single
// outstanding valid/ready bus request, stalls the pipeline until the
// response (or a timeout) and hands the raw load word to MEM.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   ex_*                  operation from EX (valid, type, address, data, masks)
//   flush                 exception/interrupt flush
//   lsu_stall             hold IF/ID/EX
//   mem_*_o               captured load result/metadata for MEM
//   lsu_exp_flag/cause    misalignment (same cycle) or bus timeout (in DONE)
//   dbus_req_*/dbus_rsp_* data bus request and response channels
module lsu_dbus_ctrl
  import lsu_dbus_ctrl_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic            ex_is_load,
  input  logic            ex_is_store,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic [3:0]      ex_s_mask,
  input  logic [4:0]      ex_l_mask,
  input  logic            flush,
  output logic            lsu_stall,
  output logic [XLEN-1:0] mem_load_data_o,
  output logic [1:0]      mem_ls_addr_2low_o,
  output logic [4:0]      mem_l_mask_o,
  output logic            mem_is_load_o,
  output logic            lsu_exp_flag,
  output logic [1:0]      lsu_exp_cause,
  output logic            dbus_req_valid,
  input  logic            dbus_req_ready,
  output logic [XLEN-1:0] dbus_req_addr,
  output logic            dbus_req_we,
  output logic [3:0]      dbus_req_wmask,
  output logic [XLEN-1:0] dbus_req_wdata,
  input  logic            dbus_rsp_valid,
  input  logic [XLEN-1:0] dbus_rsp_rdata
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_e      r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_timeout;
  logic [XLEN-1:0] r_req_addr;
  logic            r_we;
  logic [3:0]      r_wmask;
  logic [XLEN-1:0] r_wdata;
  logic [4:0]      r_l_mask;
  logic [1:0]      r_addr_lo;
  logic            r_is_load;
  logic [XLEN-1:0] r_load_data;

  logic            w_ls_op;
  logic [3:0]      w_size;
  logic            w_misalign;
  logic            w_exp_mis;
  logic            w_accept;
  logic            w_done_to;
  logic [3:0]      w_wmask;
  logic [XLEN-1:0] w_wdata;
  lsu_cause_e      w_cause;

  assign w_ls_op    = ex_valid & (ex_is_load | ex_is_store);
  assign w_size     = ex_is_store ? ex_s_mask : ex_l_mask[3:0];
  assign w_misalign = is_misaligned(w_size, ex_addr[1:0]);
  assign w_exp_mis  = (r_state == LSU_IDLE) & w_ls_op & ~flush & w_misalign;
  assign w_accept   = (r_state == LSU_IDLE) & w_ls_op & ~flush & ~w_misalign;
  assign w_done_to  = (r_state == LSU_DONE) & r_timeout;

  lsu_dbus_ctrl_store_align #(.XLEN(XLEN)) u_store_align (
    .i_addr_lo (ex_addr[1:0]),
    .i_s_mask  (ex_s_mask),
    .i_data    (ex_store_data),
    .o_wmask   (w_wmask),
    .o_wdata   (w_wdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= LSU_IDLE;
      r_cnt       <= '0;
      r_timeout   <= 1'b0;
      r_req_addr  <= '0;
      r_we        <= 1'b0;
      r_wmask     <= '0;
      r_wdata     <= '0;
      r_l_mask    <= '0;
      r_addr_lo   <= '0;
      r_is_load   <= 1'b0;
      r_load_data <= '0;
    end else begin
      case (r_state)
        LSU_IDLE: begin
          if (w_accept) begin
            r_req_addr <= {ex_addr[XLEN-1:2], 2'b00};
            r_we       <= ex_is_store;
            r_wmask    <= ex_is_store ? w_wmask : '0;
            r_wdata    <= ex_is_store ? w_wdata : '0;
            r_l_mask   <= ex_l_mask;
            r_addr_lo  <= ex_addr[1:0];
            r_is_load  <= ex_is_load;
            r_state    <= LSU_REQ;
          end
        end
        LSU_REQ: begin
          // Once the bus takes the request a response is owed, so a
          // coincident flush must drain rather than withdraw.
          if (dbus_req_ready) begin
            r_cnt   <= '0;
            r_state <= flush ? LSU_DRAIN : LSU_RSP;
          end else if (flush) begin
            r_state <= LSU_IDLE;
          end
        end
        LSU_RSP: begin
          if (flush) begin
            // A response arriving with the flush is already consumed:
            // preload the counter so DRAIN exits on its first cycle.
            r_cnt   <= dbus_rsp_valid ? CNT_LAST : '0;
            r_state <= LSU_DRAIN;
          end else if (dbus_rsp_valid) begin
            r_load_data <= dbus_rsp_rdata;
            r_timeout   <= 1'b0;
            r_state     <= LSU_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_LAST) begin
              r_load_data <= '0;
              r_timeout   <= 1'b1;
              r_state     <= LSU_DONE;
            end
          end
        end
        LSU_DRAIN: begin
          if (dbus_rsp_valid || (r_cnt == CNT_LAST)) begin
            r_state <= LSU_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        LSU_DONE: begin
          r_timeout <= 1'b0;
          r_state   <= LSU_IDLE;
        end
        default: r_state <= LSU_IDLE;
      endcase
    end
  end

  always_comb begin
    lsu_stall = 1'b0;
    case (r_state)
      LSU_IDLE:  lsu_stall = w_accept;
      LSU_REQ:   lsu_stall = 1'b1;
      LSU_RSP:   lsu_stall = 1'b1;
      LSU_DRAIN: lsu_stall = w_ls_op;
      default:   lsu_stall = 1'b0;
    endcase
  end

  always_comb begin
    w_cause = CAUSE_NONE;
    if (w_exp_mis) begin
      w_cause = ex_is_store ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
    end else if (w_done_to) begin
      w_cause = CAUSE_TIMEOUT;
    end
  end

  assign lsu_exp_flag       = w_exp_mis | w_done_to;
  assign lsu_exp_cause      = w_cause;
  assign dbus_req_valid     = (r_state == LSU_REQ);
  assign dbus_req_addr      = r_req_addr;
  assign dbus_req_we        = r_we;
  assign dbus_req_wmask     = r_wmask;
  assign dbus_req_wdata     = r_wdata;
  assign mem_load_data_o    = r_load_data;
  assign mem_ls_addr_2low_o = r_addr_lo;
  assign mem_l_mask_o       = r_l_mask;
  assign mem_is_load_o      = r_is_load;

endmodule

// File: doc/lsu_dbus_ctrl.md
Name: lsu_dbus_ctrl

Overview:
Data-bus request side of the load/store path, sitting between the EX stage and the MEM stage. It accepts a load or store from EX, checks alignment, and builds the byte write mask and lane-replicated store data. It issues a single outstanding request on a valid/ready data bus, stalls the pipeline until the response arrives, and hands the raw load word plus address low bits and load mask to MEM for extension. It is the write/issue counterpart to MEM's load-data extraction.

Parameters:
XLEN, 32, data/address width
TIMEOUT_CYCLES, 255, cycles waited in RSP before declaring bus timeout; counter width is clog2(TIMEOUT_CYCLES+1)

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
ex_valid  in  1  EX holds a valid instruction
ex_is_load  in  1  load op
ex_is_store  in  1  store op
ex_addr  in  XLEN  effective address
ex_store_data  in  XLEN  rs2 value
ex_s_mask  in  4  store size: 0001 byte, 0011 half, 1111 word
ex_l_mask  in  5  load mask; bit4 = signed, bits3:0 = size as above
flush  in  1  exception/interrupt flush (exp_int_flag)
lsu_stall  out  1  hold IF/ID/EX
mem_load_data_o  out  XLEN  raw response word
mem_ls_addr_2low_o  out  2  captured addr[1:0]
mem_l_mask_o  out  5  captured load mask
mem_is_load_o  out  1  captured load flag, valid in DONE
lsu_exp_flag  out  1  LSU exception pulse
lsu_exp_cause  out  2  00 none, 01 load misaligned, 10 store misaligned, 11 bus timeout
dbus_req_valid  out  1  request valid
dbus_req_ready  in  1  request accepted
dbus_req_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00})
dbus_req_we  out  1  1 = store
dbus_req_wmask  out  4  byte enables
dbus_req_wdata  out  XLEN  lane-replicated store data
dbus_rsp_valid  in  1  response (loads and stores)
dbus_rsp_rdata  in  XLEN  read data

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; all registered outputs 0; timeout counter 0. Reset mid-transaction abandons it; no drain is performed.
- States: IDLE, REQ, RSP, DONE, DRAIN.
- Misalignment (checked in IDLE): half with addr[0]=1, or word with addr[1:0]!=0. The result is a combinational lsu_exp_flag with cause 01 or 10 in that cycle. No request, no stall, state stays IDLE.
- IDLE: if ex_valid & (ld|st) & aligned & !flush, capture addr, we, wmask, wdata, l_mask and is_load, assert lsu_stall, and go to REQ.
- REQ: dbus_req_valid=1 with all request fields stable until dbus_req_ready.
  - On ready, go to RSP and clear the counter.
  - rsp_valid is ignored in REQ.
  - flush before ready: drop valid and go to IDLE. This is the only permitted valid withdrawal.
- RSP: on rsp_valid, capture rdata into mem_load_data_o and go to DONE. Otherwise increment the counter.
  - When the counter reaches TIMEOUT_CYCLES, go to DONE with timeout pending and mem_load_data_o = 0.
  - flush in RSP goes to DRAIN.
- DONE: lsu_stall=0 and outputs valid for exactly this cycle. Timeout raises lsu_exp_flag with cause 11 here. EX inputs are ignored. Next state is always IDLE.
- DRAIN: wait for rsp_valid (or timeout), discard data, no exception, then go to IDLE. lsu_stall = ex_valid & (ld|st).
- lsu_stall is 1 in IDLE-accept, REQ and RSP, and 0 in DONE.
- Minimum latency: accept, 1-cycle grant, 1-cycle response gives 4 cycles (accept, REQ, RSP, DONE).
- Store alignment:
  - byte: wdata = {4{d[7:0]}}, wmask = 0001 << addr[1:0]
  - half: wdata = {2{d[15:0]}}, wmask = 0011 << addr[1:0]
  - word: wdata = d, wmask = 1111
- Loads: we=0, wmask=0000, wdata=0.
- Simultaneous flush and new op in IDLE: the op is not accepted. flush has priority over rsp_valid only in the RSP to DRAIN decision. A same-cycle rsp_valid with flush is consumed by the DRAIN transition.
- Only one outstanding request, ever.

Decomposition:
- defines.v holds:
  - LSU_IDLE/REQ/RSP/DONE/DRAIN state encodings
  - mask encodings MASK_B=4'b0001, MASK_H=4'b0011, MASK_W=4'b1111
  - signed-load bit index 4
  - cause codes
- Sub-module store_align (combinational: addr[1:0], s_mask, data to wmask and wdata) is reused by any future store buffer.

Test Plan:
- SB with addr=0x1003, data=0xAABBCCDD, ready immediately, rsp after 1 cycle -> wmask=1000, wdata=0xDDDDDDDD, req_addr=0x1000, we=1, stall high 3 cycles then low.
- LH with addr=0x2002, l_mask=10011, ready delayed 3 cycles, rsp_rdata=0x8001_1234 -> req fields stable 4 cycles; DONE outputs data=0x80011234, 2low=10, l_mask=10011.
- SW with addr=0x3001 -> same-cycle lsu_exp_flag=1, cause=10, dbus_req_valid never asserted, stall=0.
- LW with no response -> after TIMEOUT_CYCLES in RSP, DONE with cause=11 and data=0; a subsequent LW proceeds normally.
- LW accepted, flush in RSP, rsp arrives 2 cycles later with a new LW on EX -> no exception, data discarded, stall held in DRAIN; the new LW issues after IDLE.
- rst_n low during REQ -> next cycle valid=0, stall=0, all outputs 0, state IDLE.
